// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of the sync-read byte-addressed data memory
// Each access runs IDLE -> ISSUE -> RESP; illegal accesses complete with err and never write memory.
module dmem_arbiter #(
   parameter int MEM_BYTES   = 1024,
   parameter int P0_PRIORITY = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_rw,
   input  logic [1:0]  p0_mode,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_resp,
   output logic        p0_err,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_rw,
   input  logic [1:0]  p1_mode,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_resp,
   output logic        p1_err,
   output logic [31:0] p1_rdata,
   output logic        mem_rw,
   output logic [1:0]  mem_mode,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   state_t      state;
   state_t      state_nxt;
   logic        last_grant;
   logic        win_id;
   logic        lat_rw;
   logic        lat_ill;
   logic [1:0]  lat_mode;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic        gnt0;
   logic        gnt1;
   logic        sel_rw;
   logic [1:0]  sel_mode;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_ill;

   // End address is formed 33 bits wide so an access near 2^32 cannot wrap past the bounds check.
   function automatic logic is_illegal(input logic [1:0] mode, input logic [31:0] addr);
      logic [32:0] end_addr;
      logic        bad;
      end_addr = {1'b0, addr} + (33'd1 << mode);
      case (mode)
         2'd1:    bad = addr[0];
         2'd2:    bad = |addr[1:0];
         2'd3:    bad = 1'b1;
         default: bad = 1'b0;
      endcase
      return bad || (end_addr > MEM_LIMIT);
   endfunction

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE && !rst) begin
         if (p0_req && p1_req) begin
            if ((P0_PRIORITY != 0) || last_grant) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
         end
      end
   end

   always_comb begin
      sel_rw    = gnt1 ? p1_rw    : p0_rw;
      sel_mode  = gnt1 ? p1_mode  : p0_mode;
      sel_addr  = gnt1 ? p1_addr  : p0_addr;
      sel_wdata = gnt1 ? p1_wdata : p0_wdata;
      sel_ill   = is_illegal(sel_mode, sel_addr);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt0 || gnt1) state_nxt = ISSUE;
         ISSUE:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         win_id     <= 1'b0;
         lat_rw     <= 1'b0;
         lat_ill    <= 1'b0;
         lat_mode   <= 2'd0;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
      end else begin
         state <= state_nxt;
         if (gnt0 || gnt1) begin
            win_id     <= gnt1;
            last_grant <= gnt1;
            lat_rw     <= sel_rw;
            lat_ill    <= sel_ill;
            lat_mode   <= sel_mode;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
         end
      end
   end

   // Memory command is not gated by rst so a write already in ISSUE still lands on that edge.
   always_comb begin
      mem_rw    = 1'b0;
      mem_mode  = 2'd0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      if (state == ISSUE) begin
         mem_rw    = lat_rw && !lat_ill;
         mem_mode  = lat_mode;
         mem_addr  = lat_addr;
         mem_wdata = lat_wdata;
      end
   end

   always_comb begin
      p0_gnt   = gnt0;
      p1_gnt   = gnt1;
      p0_resp  = 1'b0;
      p0_err   = 1'b0;
      p0_rdata = 32'd0;
      p1_resp  = 1'b0;
      p1_err   = 1'b0;
      p1_rdata = 32'd0;
      if (state == RESP && !rst) begin
         if (win_id) begin
            p1_resp  = 1'b1;
            p1_err   = lat_ill;
            p1_rdata = (!lat_rw && !lat_ill) ? mem_rdata : 32'd0;
         end else begin
            p0_resp  = 1'b1;
            p0_err   = lat_ill;
            p0_rdata = (!lat_rw && !lat_ill) ? mem_rdata : 32'd0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
